// File: rtl/crono_pkg.sv
// Shared constants for the stopwatch controller: state encodings, BCD digit
// limits and the default centisecond prescaler ratio.
package crono_pkg;

  localparam int TICK_DIV_DEF = 500000;

  localparam logic [3:0] BCD_MAX_9 = 4'd9;
  localparam logic [3:0] BCD_MAX_5 = 4'd5;

  // One-hot controller states
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_RUN   = 4'b0010;
  localparam logic [3:0] ST_PAUSE = 4'b0100;
  localparam logic [3:0] ST_LAP   = 4'b1000;

  function automatic logic st_counting(input logic [3:0] st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

endpackage

// File: rtl/crono_bcd_cnt.sv
// One BCD digit of the time chain: wraps at MAX, carry is combinational so a
// tick ripples through all digits within the same cycle.
module crono_bcd_cnt
  import crono_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX_9
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] value,
  output logic [3:0] nxt,
  output logic       carry
);

  logic [3:0] value_r;
  logic [3:0] nxt_s;

  // Next digit value: clear wins over increment
  always_comb begin
    nxt_s = value_r;
    if (clear) begin
      nxt_s = 4'd0;
    end else if (enable) begin
      if (value_r == MAX) begin
        nxt_s = 4'd0;
      end else begin
        nxt_s = value_r + 4'd1;
      end
    end else begin
      nxt_s = value_r;
    end
  end

  // Digit register, rewritten every cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      value_r <= 4'd0;
    end else begin
      value_r <= nxt_s;
    end
  end

  assign value = value_r;
  assign nxt   = nxt_s;
  assign carry = enable && (value_r == MAX);

endmodule

// File: rtl/crono_ctrl.sv
// Stopwatch controller: start/stop, lap-freeze and clear on top of a
// centisecond prescaler and a MM:SS:CC BCD chain, all outputs registered.
module crono_ctrl
  import crono_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        StartStopB,
  input  logic        LapB,
  input  logic        ZeraB,
  output logic [23:0] Tempo,
  output logic        Rodando,
  output logic        Congelado,
  output logic        Wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [3:0]    state_r;
  logic [3:0]    state_next_s;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_next_s;

  logic zera_ev_s;
  logic start_ev_s;
  logic lap_ev_s;
  logic clear_s;
  logic lap_cap_s;
  logic counting_s;
  logic tick_s;

  logic [3:0] cent_u_s, cent_d_s, seg_u_s, seg_d_s, min_u_s, min_d_s;
  logic [3:0] cent_u_n_s, cent_d_n_s, seg_u_n_s, seg_d_n_s, min_u_n_s, min_d_n_s;
  logic       cent_u_c_s, cent_d_c_s, seg_u_c_s, seg_d_c_s, min_u_c_s, min_d_c_s;

  logic [23:0] live_s;
  logic [23:0] live_next_s;
  logic [23:0] lap_r;
  logic [23:0] lap_next_s;
  logic [23:0] tempo_next_s;

  logic [23:0] tempo_r;
  logic        rodando_r;
  logic        congelado_r;
  logic        wrap_r;

  // Only the highest-priority press of a cycle survives: zera > start > lap
  assign zera_ev_s  = ~ZeraB;
  assign start_ev_s = ~StartStopB & ZeraB;
  assign lap_ev_s   = ~LapB & StartStopB & ZeraB;

  assign counting_s = st_counting(state_r);
  assign tick_s     = counting_s && (presc_r == PRESC_LAST);

  // State transitions and the clear / lap-capture strobes
  always_comb begin
    state_next_s = state_r;
    clear_s      = 1'b0;
    lap_cap_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (zera_ev_s) begin
          clear_s = 1'b1;
        end else if (start_ev_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (start_ev_s) begin
          state_next_s = ST_PAUSE;
        end else if (lap_ev_s) begin
          state_next_s = ST_LAP;
          lap_cap_s    = 1'b1;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_LAP: begin
        if (lap_ev_s) begin
          state_next_s = ST_RUN;
        end else if (start_ev_s) begin
          state_next_s = ST_PAUSE;
        end else begin
          state_next_s = ST_LAP;
        end
      end
      ST_PAUSE: begin
        if (zera_ev_s) begin
          clear_s      = 1'b1;
          state_next_s = ST_IDLE;
        end else if (start_ev_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_PAUSE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Prescaler holds in PAUSE so the sub-centisecond phase survives a pause
  always_comb begin
    presc_next_s = presc_r;
    if (clear_s) begin
      presc_next_s = {PW{1'b0}};
    end else if (tick_s) begin
      presc_next_s = {PW{1'b0}};
    end else if (counting_s) begin
      presc_next_s = presc_r + PW'(1);
    end else begin
      presc_next_s = presc_r;
    end
  end

  crono_bcd_cnt #(.MAX(BCD_MAX_9)) u_cent_u (
    .CLK(CLK), .RST(RST), .clear(clear_s), .enable(tick_s),
    .value(cent_u_s), .nxt(cent_u_n_s), .carry(cent_u_c_s)
  );
  crono_bcd_cnt #(.MAX(BCD_MAX_9)) u_cent_d (
    .CLK(CLK), .RST(RST), .clear(clear_s), .enable(cent_u_c_s),
    .value(cent_d_s), .nxt(cent_d_n_s), .carry(cent_d_c_s)
  );
  crono_bcd_cnt #(.MAX(BCD_MAX_9)) u_seg_u (
    .CLK(CLK), .RST(RST), .clear(clear_s), .enable(cent_d_c_s),
    .value(seg_u_s), .nxt(seg_u_n_s), .carry(seg_u_c_s)
  );
  crono_bcd_cnt #(.MAX(BCD_MAX_5)) u_seg_d (
    .CLK(CLK), .RST(RST), .clear(clear_s), .enable(seg_u_c_s),
    .value(seg_d_s), .nxt(seg_d_n_s), .carry(seg_d_c_s)
  );
  crono_bcd_cnt #(.MAX(BCD_MAX_9)) u_min_u (
    .CLK(CLK), .RST(RST), .clear(clear_s), .enable(seg_d_c_s),
    .value(min_u_s), .nxt(min_u_n_s), .carry(min_u_c_s)
  );
  crono_bcd_cnt #(.MAX(BCD_MAX_5)) u_min_d (
    .CLK(CLK), .RST(RST), .clear(clear_s), .enable(min_u_c_s),
    .value(min_d_s), .nxt(min_d_n_s), .carry(min_d_c_s)
  );

  assign live_s      = {min_d_s, min_u_s, seg_d_s, seg_u_s, cent_d_s, cent_u_s};
  assign live_next_s = {min_d_n_s, min_u_n_s, seg_d_n_s, seg_u_n_s, cent_d_n_s, cent_u_n_s};

  // Lap capture takes the pre-increment count; display follows the next state
  always_comb begin
    lap_next_s   = lap_r;
    tempo_next_s = live_next_s;
    if (lap_cap_s) begin
      lap_next_s = live_s;
    end else begin
      lap_next_s = lap_r;
    end
    if (state_next_s == ST_LAP) begin
      tempo_next_s = lap_next_s;
    end else begin
      tempo_next_s = live_next_s;
    end
  end

  // Control state, prescaler, lap register and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      presc_r     <= {PW{1'b0}};
      lap_r       <= 24'd0;
      tempo_r     <= 24'd0;
      rodando_r   <= 1'b0;
      congelado_r <= 1'b0;
      wrap_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      presc_r     <= presc_next_s;
      lap_r       <= lap_next_s;
      tempo_r     <= tempo_next_s;
      rodando_r   <= st_counting(state_next_s);
      congelado_r <= (state_next_s == ST_LAP);
      wrap_r      <= min_d_c_s;
    end
  end

  assign Tempo     = tempo_r;
  assign Rodando   = rodando_r;
  assign Congelado = congelado_r;
  assign Wrap      = wrap_r;

endmodule

// File: doc/crono_ctrl.md
CRONO_CTRL -- requirements
Module: crono_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 500000, sets CLK cycles per centisecond tick (50 MHz / 100 Hz).
REQ-002 CLK  input  1  system clock, 50 MHz; sole clock domain.
REQ-003 RST  input  1  reset; synchronous and active-high.
REQ-004 StartStopB  input  1  debounced start/stop press; active-low, one CLK cycle wide.
REQ-005 LapB  input  1  debounced lap press; active-low, one CLK cycle wide.
REQ-006 ZeraB  input  1  debounced clear press; active-low, one CLK cycle wide.
REQ-007 Tempo  output  24  displayed time, packed BCD {MinD,MinU,SegD,SegU,CentD,CentU}, 4 bits each.
REQ-008 Rodando  output  1  high while the timebase is counting.
REQ-009 Congelado  output  1  high while the display is lap-frozen.
REQ-010 Wrap  output  1  one-cycle pulse on rollover from 59:59:99.

Function
REQ-011 A press event SHALL be the sampled input at 0 on a CLK edge; each low cycle counts as one event.
REQ-012 FSM SHALL have one-hot states IDLE, RUN, PAUSE, LAP.
REQ-013 IDLE: start -> RUN; zera -> clear count, stay IDLE; lap ignored.
REQ-014 RUN: start -> PAUSE; lap -> LAP; zera ignored.
REQ-015 LAP: lap -> RUN; start -> PAUSE; zera ignored.
REQ-016 PAUSE: start -> RUN; zera -> clear count and prescaler, go IDLE; lap ignored.
REQ-017 Simultaneous events SHALL resolve by priority zera > start > lap; lower-priority events that cycle are discarded.
REQ-018 Prescaler SHALL count 0..TICK_DIV-1 only in RUN or LAP and issue a tick on the cycle it equals TICK_DIV-1, then return to 0.
REQ-019 Prescaler SHALL hold its value in PAUSE, preserving the sub-centisecond fraction; it is cleared only by RST or zera.
REQ-020 On a tick, the BCD chain SHALL increment in the same cycle: CentU 0-9, CentD 0-9, SegU 0-9, SegD 0-5, MinU 0-9, MinD 0-5, with carries rippling combinationally.
REQ-021 A tick at 59:59:99 SHALL yield 00:00:00, assert Wrap for exactly one cycle, and counting SHALL continue.
REQ-022 The count SHALL register on the edge after the tick cycle; Tempo is registered with no combinational path from inputs.
REQ-023 In IDLE, RUN and PAUSE, Tempo SHALL equal the live count.
REQ-024 On RUN->LAP, the lap register SHALL capture the live count as it stands before that cycle's increment; Tempo shows it while in LAP.
REQ-025 In LAP, the live count SHALL keep advancing; on leaving LAP, Tempo SHALL show the live count from the next cycle.
REQ-026 Rodando = 1 in RUN and LAP; Congelado = 1 only in LAP; both are registered and change with the state.

Reset
REQ-027 RST high on a CLK edge SHALL force IDLE; clear prescaler, live count and lap register; and drive Tempo=0, Rodando=0, Congelado=0, Wrap=0.
REQ-028 RST SHALL override any simultaneous press or tick, including mid-count and mid-LAP.

Structure
REQ-029 Package crono_pkg SHALL hold the state encodings, BCD digit limits (9, 5) and the TICK_DIV default.
REQ-030 Each digit SHALL be an instance of sub-module crono_bcd_cnt (parameter MAX; inputs clear and enable; output carry when value==MAX and enable is high).

Verification (TICK_DIV=4)
REQ-031 RST, then StartStopB low 1 cycle -> Rodando=1 next cycle; after 400 cycles Tempo=0x000100.
REQ-032 Run to 0x000512, StartStopB pulse -> Tempo holds 0x000512 for 100 cycles; second pulse resumes with the preserved prescaler phase.
REQ-033 At 0x000230, LapB pulse -> Congelado=1, Tempo frozen at 0x000230 while the live count advances; LapB again -> Tempo shows live value next cycle.
REQ-034 Preload to 0x595999 (force), one tick -> Tempo=0x000000 and Wrap high exactly one cycle.
REQ-035 In PAUSE, ZeraB and StartStopB low in the same cycle -> IDLE, Tempo=0, Rodando=0; in RUN, ZeraB alone -> no effect.
REQ-036 RST asserted in LAP with a tick due that cycle -> all outputs 0 and state IDLE on the next edge.
